host_frame_parser: RTL and testbench
====================================

// Module: host_frame_parser
// PURPOSE
//  Parametrised successor to the fixed 16-bit host command decoder. Accepts framed host commands
//  (dest, cmd, len_hi, len_lo, payload, csum_hi, csum_lo) from the host_in FIFO stream.
//  Buffers each payload internally and releases it downstream only after the 32-bit checksum matches.
//  Sits between the FX2 host interface and the slot/global command dispatch logic, in the clk_host domain.
// PARAMETERS
//  HOST_WIDTH    16    word width of in_data/out_data; must be >=16
//  LOG_MAX_LEN   10    payload buffer depth = 2**LOG_MAX_LEN words; longer frames rejected
//  TIMEOUT_CYCLES 4096 idle in_valid cycles tolerated mid-frame before abort; 0 disables
// PORTS
//  clk_host     in   1            clock; all logic on rising edge
//  reset_n      in   1            synchronous, active-low reset
//  in_data      in   HOST_WIDTH   host word
//  in_valid     in   1            host word valid
//  in_ready     out  1            parser accepts word (transfer = in_valid & in_ready)
//  out_dest     out  8            destination of released frame (0xFF = global)
//  out_cmd      out  8            command of released frame
//  out_data     out  HOST_WIDTH   payload word
//  out_empty    out  1            beat carries no payload (zero-length frame)
//  out_last     out  1            final beat of frame
//  out_valid    out  1            output beat valid
//  out_ready    in   1            downstream accepts beat
//  err_valid    out  1            one-cycle pulse: frame rejected
//  err_code     out  2            1 checksum mismatch, 2 overlength, 3 timeout; held until next err
//  frame_count  out  16           good frames released, saturating
//  err_count    out  16           rejected frames, saturating
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state=DEST, in_ready=0 that cycle then 1; out_valid, err_valid,
//   out_last, out_empty=0; err_code, frame_count, err_count, sum, length, timer=0.
//   Reset mid-frame or mid-release discards frame, without counting or flagging it.
//  Header fields use in_data[7:0] (dest, cmd, len_hi) or [15:0] (len_lo, csum_hi, csum_lo);
//   upper bits are ignored. length = {len_hi[7:0], len_lo[15:0]} (24 bits).
//  States: DEST -> CMD -> LEN_HI -> LEN_LO -> {PAYLOAD | CSUM_HI | DRAIN} -> CSUM_HI -> CSUM_LO
//   -> {RELEASE | DEST}. One transition per accepted word; in_ready=1 in every state except RELEASE.
//  LEN_LO: length==0 -> CSUM_HI; length>2**LOG_MAX_LEN -> DRAIN; else PAYLOAD.
//  PAYLOAD: writes word to buffer[idx]; sum += zero-extended word, modulo 2**32; after the
//   length-th word -> CSUM_HI.
//  DRAIN: consumes length words without storing, then consumes csum_hi and csum_lo without
//   comparing. Then err_code=2 and goes to DEST.
//  CSUM_LO: compares {csum_hi, csum_lo} with sum. Match -> RELEASE. Mismatch -> err pulse
//   with code 1 and goes to DEST; buffer contents are discarded.
//  RELEASE: out_valid is asserted the cycle after csum_lo is accepted. out_data = buffer[idx],
//   and idx advances on out_valid&out_ready. out_last=1 on the final beat. A zero-length frame
//   gives one beat with out_empty=1 and out_last=1. Final handshake: frame_count++, -> DEST.
//   out_dest, out_cmd and out_data are stable while out_valid=1 and out_ready=0.
//  Timeout: the timer counts cycles with in_valid=0 in any state other than DEST or RELEASE.
//   It clears on every accepted word. Reaching TIMEOUT_CYCLES -> err pulse with code 3 and
//   goes to DEST.
//  Every err pulse increments err_count. Counters saturate at 0xFFFF.
//  Throughput: 1 word/cycle in; 1 beat/cycle out when out_ready=1. No input during RELEASE.
// TESTING
//  T1 dest 2, cmd 0x01, len 4, data 1,2,3,4, csum 0x0000000A -> 4 beats dest=2 cmd=1 data 1..4,
//     out_last on beat 4, frame_count=1, no err.
//  T2 same frame with csum 0x0000000B -> err_valid pulse, err_code=1, no out_valid, err_count=1;
//     a following T1 frame is released normally.
//  T3 len 1025 (LOG_MAX_LEN=10), 1025 words, any csum -> all words consumed, err_code=2,
//     no output; the next frame parses correctly.
//  T4 len 0, csum 0 -> single beat with out_empty=1 and out_last=1; frame_count increments.
//  T5 T1 frame with out_ready toggling 1,0,0,1,... -> data 1..4 in order, no duplicate or lost
//     beats, outputs stable while stalled, in_ready=0 until last handshake.
//  T6 stop in_valid after 2 payload words for TIMEOUT_CYCLES -> err_code=3; reset_n low mid-frame
//     -> counters 0 and next frame OK.

Source files
------------

// File: rtl/host_frame_parser.sv
// Framed host command parser: buffers each payload and releases it downstream
// only after the 32-bit additive checksum matches.
module host_frame_parser #(
   parameter int HOST_WIDTH     = 16,
   parameter int LOG_MAX_LEN    = 10,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk_host,
   input  logic                  reset_n,
   input  logic [HOST_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [7:0]            out_dest,
   output logic [7:0]            out_cmd,
   output logic [HOST_WIDTH-1:0] out_data,
   output logic                  out_empty,
   output logic                  out_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  err_valid,
   output logic [1:0]            err_code,
   output logic [15:0]           frame_count,
   output logic [15:0]           err_count
);

   // state      | meaning
   // S_DEST     | waiting for destination word (idle)
   // S_CMD      | waiting for command word
   // S_LEN_HI   | waiting for length bits [23:16]
   // S_LEN_LO   | waiting for length bits [15:0], picks payload/drain/checksum path
   // S_PAYLOAD  | storing payload words and accumulating the sum
   // S_DRAIN    | discarding an overlength payload plus both checksum words
   // S_CSUM_HI  | waiting for checksum bits [31:16]
   // S_CSUM_LO  | waiting for checksum bits [15:0], compares against the sum
   // S_RELEASE  | streaming the buffered frame downstream, input stalled
   typedef enum logic [3:0] {
      S_DEST, S_CMD, S_LEN_HI, S_LEN_LO, S_PAYLOAD,
      S_DRAIN, S_CSUM_HI, S_CSUM_LO, S_RELEASE
   } state_t;

   localparam int          DEPTH   = 2 ** LOG_MAX_LEN;
   localparam logic [24:0] MAX_LEN = 25'(DEPTH);
   localparam logic [31:0] TMO     = 32'(TIMEOUT_CYCLES);

   state_t                  state_q, state_d;
   logic                    in_ready_q, in_ready_d;
   logic [7:0]              dest_q, dest_d;
   logic [7:0]              cmd_q, cmd_d;
   logic [7:0]              len_hi_q, len_hi_d;
   logic [23:0]             length_q, length_d;
   logic [24:0]             idx_q, idx_d;
   logic [31:0]             sum_q, sum_d;
   logic [15:0]             csum_hi_q, csum_hi_d;
   logic [31:0]             timer_q, timer_d;
   logic [HOST_WIDTH-1:0]   out_data_q, out_data_d;
   logic                    out_valid_q, out_valid_d;
   logic                    out_last_q, out_last_d;
   logic                    out_empty_q, out_empty_d;
   logic                    err_valid_q, err_valid_d;
   logic [1:0]              err_code_q, err_code_d;
   logic [15:0]             frame_count_q, frame_count_d;
   logic [15:0]             err_count_q, err_count_d;

   logic                    in_fire;
   logic                    wr_en;
   logic [HOST_WIDTH-1:0]   buf_mem [DEPTH];

   assign in_fire = in_valid & in_ready_q;

   always_comb begin
      state_d       = state_q;
      dest_d        = dest_q;
      cmd_d         = cmd_q;
      len_hi_d      = len_hi_q;
      length_d      = length_q;
      idx_d         = idx_q;
      sum_d         = sum_q;
      csum_hi_d     = csum_hi_q;
      timer_d       = timer_q;
      out_data_d    = out_data_q;
      out_valid_d   = out_valid_q;
      out_last_d    = out_last_q;
      out_empty_d   = out_empty_q;
      err_valid_d   = 1'b0;
      err_code_d    = err_code_q;
      frame_count_d = frame_count_q;
      err_count_d   = err_count_q;
      wr_en         = 1'b0;

      case (state_q)
         S_DEST: if (in_fire) begin
            dest_d  = in_data[7:0];
            sum_d   = '0;
            idx_d   = '0;
            state_d = S_CMD;
         end
         S_CMD: if (in_fire) begin
            cmd_d   = in_data[7:0];
            state_d = S_LEN_HI;
         end
         S_LEN_HI: if (in_fire) begin
            len_hi_d = in_data[7:0];
            state_d  = S_LEN_LO;
         end
         S_LEN_LO: if (in_fire) begin
            length_d = {len_hi_q, in_data[15:0]};
            idx_d    = '0;
            if (length_d == '0)                  state_d = S_CSUM_HI;
            else if ({1'b0, length_d} > MAX_LEN) state_d = S_DRAIN;
            else                                 state_d = S_PAYLOAD;
         end
         S_PAYLOAD: if (in_fire) begin
            wr_en = 1'b1;
            sum_d = sum_q + 32'(in_data);
            idx_d = idx_q + 25'd1;
            if (idx_d == {1'b0, length_q}) state_d = S_CSUM_HI;
         end
         S_DRAIN: if (in_fire) begin
            // payload words and both checksum words are swallowed here
            idx_d = idx_q + 25'd1;
            if (idx_q == {1'b0, length_q} + 25'd1) begin
               err_valid_d = 1'b1;
               err_code_d  = 2'd2;
               state_d     = S_DEST;
            end
         end
         S_CSUM_HI: if (in_fire) begin
            csum_hi_d = in_data[15:0];
            state_d   = S_CSUM_LO;
         end
         S_CSUM_LO: if (in_fire) begin
            if ({csum_hi_q, in_data[15:0]} == sum_q) begin
               out_valid_d = 1'b1;
               out_data_d  = buf_mem[0];
               out_empty_d = (length_q == '0);
               out_last_d  = (length_q <= 24'd1);
               idx_d       = 25'd1;
               state_d     = S_RELEASE;
            end else begin
               err_valid_d = 1'b1;
               err_code_d  = 2'd1;
               state_d     = S_DEST;
            end
         end
         S_RELEASE: if (out_valid_q && out_ready) begin
            if (out_last_q) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               out_empty_d = 1'b0;
               if (frame_count_q != 16'hFFFF) frame_count_d = frame_count_q + 16'd1;
               state_d = S_DEST;
            end else begin
               out_data_d = buf_mem[idx_q[LOG_MAX_LEN-1:0]];
               idx_d      = idx_q + 25'd1;
               out_last_d = (idx_d == {1'b0, length_q});
            end
         end
         default: state_d = S_DEST;
      endcase

      // idle timer only runs while a frame is partially received
      if (TIMEOUT_CYCLES != 0 && state_q != S_DEST && state_q != S_RELEASE) begin
         if (in_fire) begin
            timer_d = '0;
         end else if (!in_valid) begin
            timer_d = timer_q + 32'd1;
            if (timer_d == TMO) begin
               timer_d     = '0;
               err_valid_d = 1'b1;
               err_code_d  = 2'd3;
               state_d     = S_DEST;
            end
         end
      end else begin
         timer_d = '0;
      end

      if (err_valid_d && err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
      in_ready_d = (state_d != S_RELEASE);
   end

   always_ff @(posedge clk_host) begin
      if (!reset_n) begin
         state_q       <= S_DEST;
         in_ready_q    <= 1'b0;
         dest_q        <= '0;
         cmd_q         <= '0;
         len_hi_q      <= '0;
         length_q      <= '0;
         idx_q         <= '0;
         sum_q         <= '0;
         csum_hi_q     <= '0;
         timer_q       <= '0;
         out_data_q    <= '0;
         out_valid_q   <= 1'b0;
         out_last_q    <= 1'b0;
         out_empty_q   <= 1'b0;
         err_valid_q   <= 1'b0;
         err_code_q    <= '0;
         frame_count_q <= '0;
         err_count_q   <= '0;
      end else begin
         state_q       <= state_d;
         in_ready_q    <= in_ready_d;
         dest_q        <= dest_d;
         cmd_q         <= cmd_d;
         len_hi_q      <= len_hi_d;
         length_q      <= length_d;
         idx_q         <= idx_d;
         sum_q         <= sum_d;
         csum_hi_q     <= csum_hi_d;
         timer_q       <= timer_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
         out_last_q    <= out_last_d;
         out_empty_q   <= out_empty_d;
         err_valid_q   <= err_valid_d;
         err_code_q    <= err_code_d;
         frame_count_q <= frame_count_d;
         err_count_q   <= err_count_d;
      end
   end

   always_ff @(posedge clk_host) begin
      if (wr_en) buf_mem[idx_q[LOG_MAX_LEN-1:0]] <= in_data;
   end

   assign in_ready    = in_ready_q;
   assign out_dest    = dest_q;
   assign out_cmd     = cmd_q;
   assign out_data    = out_data_q;
   assign out_empty   = out_empty_q;
   assign out_last    = out_last_q;
   assign out_valid   = out_valid_q;
   assign err_valid   = err_valid_q;
   assign err_code    = err_code_q;
   assign frame_count = frame_count_q;
   assign err_count   = err_count_q;

endmodule

// File: tb/tb_host_frame_parser.sv
// Bench for host_frame_parser: expected beats queued at drive time, popped by a
// monitor as the parser releases them.
module tb_host_frame_parser;

   localparam int TMO = 64;

   logic        clk_host = 1'b0;
   logic        reset_n;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out_dest, out_cmd;
   logic [15:0] out_data;
   logic        out_empty, out_last, out_valid, out_ready;
   logic        err_valid;
   logic [1:0]  err_code;
   logic [15:0] frame_count, err_count;

   host_frame_parser #(.HOST_WIDTH(16), .LOG_MAX_LEN(10), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_host(clk_host), .reset_n(reset_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_dest(out_dest), .out_cmd(out_cmd), .out_data(out_data),
      .out_empty(out_empty), .out_last(out_last), .out_valid(out_valid),
      .out_ready(out_ready), .err_valid(err_valid), .err_code(err_code),
      .frame_count(frame_count), .err_count(err_count)
   );

   always #5 clk_host = ~clk_host;

   typedef struct packed {
      logic [7:0]  dest;
      logic [7:0]  cmd;
      logic        last;
      logic        empty;
      logic [15:0] data;
   } beat_t;

   beat_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    err_seen = 0;
   bit    ready_mode = 1'b0;
   int    rdy_cnt = 0;
   bit    stalled_prev = 1'b0;
   beat_t prev_beat;

   // out_ready pattern 1,0,0 repeating in stall mode
   always @(posedge clk_host) begin
      #1;
      rdy_cnt   = (rdy_cnt == 2) ? 0 : rdy_cnt + 1;
      out_ready = ready_mode ? (rdy_cnt == 0) : 1'b1;
   end

   always @(negedge clk_host) begin
      beat_t act, exp;
      if (reset_n === 1'b1) begin
         act = '{out_dest, out_cmd, out_last, out_empty, out_empty ? 16'h0 : out_data};
         if (err_valid) err_seen++;
         if (out_valid) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL in_ready_during_release got %b want 0", in_ready);
            end
         end
         if (stalled_prev) begin
            checks++;
            if (out_valid !== 1'b1 || act !== prev_beat) begin
               errors++;
               $display("FAIL stall_hold got v=%b %h want v=1 %h", out_valid, act, prev_beat);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat got %h want none", act);
            end else begin
               exp = exp_q.pop_front();
               if (act !== exp) begin
                  errors++;
                  $display("FAIL beat got %h want %h", act, exp);
               end
            end
         end
         stalled_prev = out_valid && !out_ready;
         prev_beat    = act;
      end else begin
         stalled_prev = 1'b0;
      end
   end

   function automatic logic [31:0] calc_sum(input int len, input logic [15:0] base);
      logic [31:0] s;
      s = 32'd0;
      for (int i = 0; i < len; i++) s = s + 32'(16'(base + 16'(i)));
      return s;
   endfunction

   task automatic send_word(input logic [15:0] w);
      int guard;
      guard = 0;
      @(negedge clk_host);
      in_data  = w;
      in_valid = 1'b1;
      while (!in_ready && guard < 5000) begin
         @(negedge clk_host);
         guard++;
      end
      if (guard >= 5000) begin
         checks++;
         errors++;
         $display("FAIL in_ready_wait got 0 want 1");
      end
      @(posedge clk_host);
   endtask

   task automatic send_header(input logic [7:0] dest, input logic [7:0] cmd, input int len);
      send_word({8'hA5, dest});
      send_word({8'h5A, cmd});
      send_word({8'hC3, 8'(len >> 16)});
      send_word(16'(len));
   endtask

   task automatic send_frame(input logic [7:0] dest, input logic [7:0] cmd, input int len,
                             input logic [15:0] base, input logic [31:0] csum, input bit ok);
      logic [15:0] w;
      send_header(dest, cmd, len);
      for (int i = 0; i < len; i++) begin
         w = 16'(base + 16'(i));
         if (ok) exp_q.push_back('{dest, cmd, (i == len - 1), 1'b0, w});
         send_word(w);
      end
      if (ok && len == 0) exp_q.push_back('{dest, cmd, 1'b1, 1'b1, 16'h0});
      send_word(csum[31:16]);
      send_word(csum[15:0]);
      @(negedge clk_host);
      in_valid = 1'b0;
   endtask

   task automatic wait_release();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 5000) begin
         @(negedge clk_host);
         guard++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL release_timeout got %0d beats left want 0", exp_q.size());
         exp_q.delete();
      end
      repeat (4) @(negedge clk_host);
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk_host);
      #1;
      checks++;
      if ({in_ready, out_valid, err_valid, out_last, out_empty} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags got %b want 00000",
                  {in_ready, out_valid, err_valid, out_last, out_empty});
      end
      checks++;
      if ({err_code, frame_count, err_count} !== 34'b0) begin
         errors++;
         $display("FAIL reset_counters got code=%0d fc=%0d ec=%0d want 0 0 0",
                  err_code, frame_count, err_count);
      end
      @(negedge clk_host);
      reset_n = 1'b1;
      @(posedge clk_host);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset got %b want 1", in_ready);
      end
   endtask

   task automatic test_good_frame(input logic [15:0] fc_exp);
      int e0;
      e0 = err_seen;
      send_frame(8'h02, 8'h01, 4, 16'h1, 32'h0000000A, 1'b1);
      wait_release();
      checks++;
      if (frame_count !== fc_exp || err_seen != e0) begin
         errors++;
         $display("FAIL good_frame got fc=%0d errs=%0d want fc=%0d errs=0",
                  frame_count, err_seen - e0, fc_exp);
      end
   endtask

   task automatic test_bad_csum();
      int e0;
      e0 = err_seen;
      send_frame(8'h02, 8'h01, 4, 16'h1, 32'h0000000B, 1'b0);
      repeat (4) @(negedge clk_host);
      checks++;
      if (err_seen - e0 != 1 || err_code !== 2'd1 || err_count !== 16'd1 || frame_count !== 16'd1) begin
         errors++;
         $display("FAIL bad_csum got pulses=%0d code=%0d ec=%0d fc=%0d want 1 1 1 1",
                  err_seen - e0, err_code, err_count, frame_count);
      end
      test_good_frame(16'd2);
   endtask

   task automatic test_overlength();
      int e0;
      e0 = err_seen;
      send_frame(8'h07, 8'h33, 1025, 16'h0, 32'h12345678, 1'b0);
      repeat (4) @(negedge clk_host);
      checks++;
      if (err_seen - e0 != 1 || err_code !== 2'd2 || err_count !== 16'd2) begin
         errors++;
         $display("FAIL overlength got pulses=%0d code=%0d ec=%0d want 1 2 2",
                  err_seen - e0, err_code, err_count);
      end
      test_good_frame(16'd3);
      send_frame(8'hFF, 8'h44, 1024, 16'hFF80, calc_sum(1024, 16'hFF80), 1'b1);
      wait_release();
      checks++;
      if (frame_count !== 16'd4 || err_count !== 16'd2) begin
         errors++;
         $display("FAIL max_len got fc=%0d ec=%0d want 4 2", frame_count, err_count);
      end
   endtask

   task automatic test_zero_len();
      send_frame(8'h10, 8'h20, 0, 16'h0, 32'h0, 1'b1);
      wait_release();
      checks++;
      if (frame_count !== 16'd5) begin
         errors++;
         $display("FAIL zero_len got fc=%0d want 5", frame_count);
      end
   endtask

   task automatic test_back_to_back_stall();
      ready_mode = 1'b1;
      send_frame(8'h02, 8'h01, 4, 16'h1, 32'h0000000A, 1'b1);
      wait_release();
      ready_mode = 1'b0;
      send_frame(8'h03, 8'h09, 3, 16'hFFFE, calc_sum(3, 16'hFFFE), 1'b1);
      wait_release();
      checks++;
      if (frame_count !== 16'd7) begin
         errors++;
         $display("FAIL stall_frames got fc=%0d want 7", frame_count);
      end
   endtask

   task automatic test_timeout_and_reset();
      int n;
      send_header(8'h02, 8'h01, 4);
      send_word(16'h1);
      send_word(16'h2);
      @(negedge clk_host);
      in_valid = 1'b0;
      n = 0;
      while (n < TMO + 50) begin
         @(negedge clk_host);
         n++;
         if (err_valid) break;
      end
      checks++;
      if (n != TMO || err_code !== 2'd3 || err_count !== 16'd3) begin
         errors++;
         $display("FAIL timeout got cycles=%0d code=%0d ec=%0d want %0d 3 3",
                  n, err_code, err_count, TMO);
      end
      send_header(8'h02, 8'h01, 4);
      send_word(16'h1);
      @(negedge clk_host);
      in_valid = 1'b0;
      reset_n  = 1'b0;
      @(negedge clk_host);
      reset_n = 1'b1;
      checks++;
      if (frame_count !== 16'd0 || err_count !== 16'd0 || err_code !== 2'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset got fc=%0d ec=%0d code=%0d ov=%b want 0 0 0 0",
                  frame_count, err_count, err_code, out_valid);
      end
      test_good_frame(16'd1);
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      in_data   = 16'h0;
      out_ready = 1'b1;
      test_reset();
      test_good_frame(16'd1);
      test_bad_csum();
      test_overlength();
      test_zero_len();
      test_back_to_back_stall();
      test_timeout_and_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
